// File: rtl/result_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : result_demux                                                   |
// | Purpose : Routes one input word to one of three output channels. Each    |
// |           channel has a one-entry buffer with valid/ready handshakes.    |
// |           Select value 3 is illegal. Such a word is accepted and         |
// |           dropped, and it raises a one-cycle err pulse and a saturating  |
// |           8-bit error count.                                             |
// | Ports   : clk, rst_n (synchronous, active-low)                           |
// |           in_data/in_sel/in_valid -> in_ready     input handshake        |
// |           outN_data/outN_valid <- outN_ready      per-channel output     |
// |           err, err_count                          illegal-select report  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module result_demux #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic             out0_valid,
  output logic             out1_valid,
  output logic             out2_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  input  logic             out2_ready,
  output logic             err,
  output logic [7:0]       err_count
);

  localparam logic [1:0] c_SEL_ILLEGAL = 2'd3;
  localparam logic [7:0] c_CNT_MAX     = 8'hFF;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  logic [2:0]            w_ch_valid;
  logic [2:0]            w_ch_ready;
  logic [2:0][WIDTH-1:0] w_ch_data;
  logic                  w_in_xfer;
  logic                  w_illegal;

  assign w_ch_ready = {out2_ready, out1_ready, out0_ready};

  // The selected channel can take a word if it is empty, or if it is full and
  // drains in this same cycle. Unselected channels never gate the input.
  // During reset nothing is accepted.
  always_comb begin
    in_ready = 1'b0;
    case (in_sel)
      2'd0:    in_ready = !w_ch_valid[0] || w_ch_ready[0];
      2'd1:    in_ready = !w_ch_valid[1] || w_ch_ready[1];
      2'd2:    in_ready = !w_ch_valid[2] || w_ch_ready[2];
      default: in_ready = 1'b1;
    endcase
    in_ready = in_ready && rst_n;
  end

  assign w_in_xfer = in_valid && in_ready;
  assign w_illegal = w_in_xfer && (in_sel == c_SEL_ILLEGAL);

  generate
    for (genvar i = 0; i < 3; i++) begin : g_ch
      localparam logic [1:0] c_SEL = 2'(i);

      ch_state_e        state_q, state_d;
      logic [WIDTH-1:0] data_q,  data_d;
      logic             w_wr;
      logic             w_rd;

      assign w_wr = w_in_xfer && (in_sel == c_SEL);
      assign w_rd = (state_q == FULL) && w_ch_ready[i];

      always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (w_wr) begin
          // A write wins over a concurrent drain, so the buffer stays full
          // and holds the new word.
          state_d = FULL;
          data_d  = in_data;
        end else if (w_rd) begin
          state_d = EMPTY;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_q <= EMPTY;
          data_q  <= '0;
        end else begin
          state_q <= state_d;
          data_q  <= data_d;
        end
      end

      assign w_ch_valid[i] = (state_q == FULL);
      assign w_ch_data[i]  = data_q;
    end
  endgenerate

  logic       err_q, err_d;
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_d       = w_illegal;
    err_count_d = err_count_q;
    if (w_illegal && (err_count_q != c_CNT_MAX)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out0_data  = w_ch_data[0];
  assign out1_data  = w_ch_data[1];
  assign out2_data  = w_ch_data[2];
  assign out0_valid = w_ch_valid[0];
  assign out1_valid = w_ch_valid[1];
  assign out2_valid = w_ch_valid[2];
  assign err        = err_q;
  assign err_count  = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_result_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_result_demux                                                |
// | Purpose : Self-checking bench for result_demux. It applies a table of    |
// |           directed vectors and then hand-written illegal-select          |
// |           sequences.                                                     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_result_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0_data, out1_data, out2_data;
  logic        out0_valid, out1_valid, out2_valid;
  logic        out0_ready, out1_ready, out2_ready;
  logic        err;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  result_demux #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out1_data  (out1_data),
    .out2_data  (out2_data),
    .out0_valid (out0_valid),
    .out1_valid (out1_valid),
    .out2_valid (out2_valid),
    .out0_ready (out0_ready),
    .out1_ready (out1_ready),
    .out2_ready (out2_ready),
    .err        (err),
    .err_count  (err_count)
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  sel;
    logic        vld;
    logic [31:0] d;
    logic [2:0]  ordy;    // {out2_ready, out1_ready, out0_ready}
    logic        e_rdy;   // in_ready expected before the edge
    logic [2:0]  e_v;     // {out2_valid, out1_valid, out0_valid} after the edge
    logic [31:0] e_d0, e_d1, e_d2;
    logic        e_err;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] s, input logic v,
                       input logic [31:0] d, input logic [2:0] o);
    rst_n      = r;
    in_sel     = s;
    in_valid   = v;
    in_data    = d;
    {out2_ready, out1_ready, out0_ready} = o;
  endtask

  task automatic set_vec(input int i, input logic r, input logic [1:0] s, input logic v,
                         input logic [31:0] d, input logic [2:0] o, input logic er,
                         input logic [2:0] ev, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic ee, input logic [7:0] ec);
    vecs[i] = '{rst_n:r, sel:s, vld:v, d:d, ordy:o, e_rdy:er, e_v:ev,
                e_d0:d0, e_d1:d1, e_d2:d2, e_err:ee, e_cnt:ec};
  endtask

  initial begin
    // Reset, then reset with a valid input which must not be accepted.
    set_vec(0,  0, 2'd0, 0, 32'h0,        3'b000, 0, 3'b000, 32'h0,  32'h0,        32'h0,  0, 8'd0);
    set_vec(1,  0, 2'd1, 1, 32'hDEADBEEF, 3'b000, 0, 3'b000, 32'h0,  32'h0,        32'h0,  0, 8'd0);
    // First accept right after reset release. The word then holds for 5 cycles, then stalls.
    set_vec(2,  1, 2'd1, 1, 32'hDEADBEEF, 3'b000, 1, 3'b010, 32'h0,  32'hDEADBEEF, 32'h0,  0, 8'd0);
    for (int i = 3; i < 8; i++)
      set_vec(i, 1, 2'd1, 0, 32'h0,       3'b000, 0, 3'b010, 32'h0,  32'hDEADBEEF, 32'h0,  0, 8'd0);
    set_vec(8,  1, 2'd1, 1, 32'h55,       3'b000, 0, 3'b010, 32'h0,  32'hDEADBEEF, 32'h0,  0, 8'd0);
    set_vec(9,  1, 2'd0, 0, 32'h0,        3'b010, 1, 3'b000, 32'h0,  32'hDEADBEEF, 32'h0,  0, 8'd0);
    // ch2 full and stalled, then released with a write in the same cycle.
    set_vec(10, 1, 2'd2, 1, 32'h11,       3'b000, 1, 3'b100, 32'h0,  32'hDEADBEEF, 32'h11, 0, 8'd0);
    set_vec(11, 1, 2'd2, 1, 32'h22,       3'b000, 0, 3'b100, 32'h0,  32'hDEADBEEF, 32'h11, 0, 8'd0);
    set_vec(12, 1, 2'd2, 1, 32'h22,       3'b100, 1, 3'b100, 32'h0,  32'hDEADBEEF, 32'h22, 0, 8'd0);
    set_vec(13, 1, 2'd2, 0, 32'h0,        3'b100, 1, 3'b000, 32'h0,  32'hDEADBEEF, 32'h22, 0, 8'd0);
    // Full-throughput stream into ch0.
    for (int i = 0; i < 4; i++)
      set_vec(14 + i, 1, 2'd0, 1, 32'(i + 1), 3'b001, 1, 3'b001, 32'(i + 1), 32'hDEADBEEF, 32'h22, 0, 8'd0);
    set_vec(18, 1, 2'd0, 0, 32'h0,        3'b001, 1, 3'b000, 32'h4,  32'hDEADBEEF, 32'h22, 0, 8'd0);
    // ch1 stalled full. A write to ch0 must leave ch1 untouched.
    set_vec(19, 1, 2'd1, 1, 32'hABCD,     3'b000, 1, 3'b010, 32'h4,  32'hABCD,     32'h22, 0, 8'd0);
    set_vec(20, 1, 2'd0, 1, 32'h77,       3'b000, 1, 3'b011, 32'h77, 32'hABCD,     32'h22, 0, 8'd0);
    set_vec(21, 1, 2'd1, 1, 32'h99,       3'b000, 0, 3'b011, 32'h77, 32'hABCD,     32'h22, 0, 8'd0);
    set_vec(22, 1, 2'd2, 1, 32'h33,       3'b000, 1, 3'b111, 32'h77, 32'hABCD,     32'h33, 0, 8'd0);
    // One illegal drop, then a mid-operation reset discards everything.
    set_vec(23, 1, 2'd3, 1, 32'hFF,       3'b000, 1, 3'b111, 32'h77, 32'hABCD,     32'h33, 1, 8'd1);
    set_vec(24, 0, 2'd0, 1, 32'h12,       3'b111, 0, 3'b000, 32'h0,  32'h0,        32'h0,  0, 8'd0);
    set_vec(25, 1, 2'd0, 1, 32'h5A,       3'b000, 1, 3'b001, 32'h5A, 32'h0,        32'h0,  0, 8'd0);

    drive(0, 2'd0, 0, 32'h0, 3'b000);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].sel, vecs[i].vld, vecs[i].d, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valids", i), 32'({out2_valid, out1_valid, out0_valid}), 32'(vecs[i].e_v));
      chk($sformatf("v%0d out0_data", i), out0_data, vecs[i].e_d0);
      chk($sformatf("v%0d out1_data", i), out1_data, vecs[i].e_d1);
      chk($sformatf("v%0d out2_data", i), out2_data, vecs[i].e_d2);
      chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d err_count", i), 32'(err_count), 32'(vecs[i].e_cnt));
    end

    // Drain ch0 so that no channel is valid.
    @(negedge clk);
    drive(1, 2'd0, 0, 32'h0, 3'b001);
    @(posedge clk);
    #1;
    chk("drain valids", 32'({out2_valid, out1_valid, out0_valid}), 32'h0);

    // Three illegal accepts with an idle gap: three err pulses, count reaches 3.
    begin
      logic [3:0] pat;
      int         cnt;
      pat = 4'b1101;  // bit k set means an illegal accept in step k
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        drive(1, 2'd3, pat[k], 32'hBAD0 + 32'(k), 3'b000);
        #1;
        chk($sformatf("ill%0d in_ready", k), 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        if (pat[k]) cnt++;
        chk($sformatf("ill%0d err", k), 32'(err), 32'(pat[k]));
        chk($sformatf("ill%0d err_count", k), 32'(err_count), 32'(cnt));
        chk($sformatf("ill%0d valids", k), 32'({out2_valid, out1_valid, out0_valid}), 32'h0);
      end
      chk("ill3 final count", 32'(err_count), 32'd3);
    end

    // 297 more illegal accepts bring the total to 300. The count saturates at 255.
    for (int k = 0; k < 297; k++) begin
      @(negedge clk);
      drive(1, 2'd3, 1, 32'(k), 3'b000);
      @(posedge clk);
      #1;
      if (k == 250) chk("sat 254", 32'(err_count), 32'd254);
      if (k == 251) chk("sat 255", 32'(err_count), 32'd255);
    end
    chk("sat err", 32'(err), 32'h1);
    chk("sat err_count", 32'(err_count), 32'd255);
    chk("sat valids", 32'({out2_valid, out1_valid, out0_valid}), 32'h0);

    @(negedge clk);
    drive(1, 2'd3, 0, 32'h0, 3'b000);
    @(posedge clk);
    #1;
    chk("idle err", 32'(err), 32'h0);
    chk("idle err_count", 32'(err_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_demux.md
RESULT_DEMUX -- requirements
Module: result_demux

Interface
REQ-001 Parameter: WIDTH, 32, data width of the input and of each output channel.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous and active-low.
REQ-004 Port: in_data  input  WIDTH  word to route.
REQ-005 Port: in_sel  input  2  destination: 0 selects ch0, 1 selects ch1, 2 selects ch2, 3 is illegal.
REQ-006 Port: in_valid  input  1  in_data and in_sel are valid this cycle.
REQ-007 Port: in_ready  output  1  block accepts the input this cycle.
REQ-008 Port: out0_data, out1_data, out2_data  output  WIDTH  per-channel registered data.
REQ-009 Port: out0_valid, out1_valid, out2_valid  output  1  channel holds an undelivered word.
REQ-010 Port: out0_ready, out1_ready, out2_ready  input  1  channel consumer accepts the word.
REQ-011 Port: err  output  1  one-cycle pulse, asserted the cycle after an illegal select is accepted.
REQ-012 Port: err_count  output  8  saturating count of accepted illegal selects.

Function
REQ-013 Each channel shall have a 1-entry buffer with two states: EMPTY (outN_valid=0) and FULL (outN_valid=1).
REQ-014 A transfer on the input shall occur when in_valid=1 and in_ready=1; a transfer on channel N shall occur when outN_valid=1 and outN_ready=1.
REQ-015 in_ready shall be combinational: 1 when in_sel=3, or when the selected channel is EMPTY, or when the selected channel is FULL and its outN_ready=1 this cycle.
REQ-016 in_ready shall not depend on in_valid, and it shall not depend on unselected channels.
REQ-017 An accepted word for channel N shall appear on outN_data with outN_valid=1 on the next cycle (latency 1).
REQ-018 Transitions for channel N: EMPTY to FULL on an accepted write; FULL to EMPTY on an output transfer with no write; FULL stays FULL with new data on a simultaneous output transfer and write; otherwise the state holds.
REQ-019 outN_data shall hold stable while outN_valid=1 and outN_ready=0.
REQ-020 A write to channel N shall not alter other channels' data or valid.
REQ-021 Only the selected channel's buffer shall be loaded from in_data; unselected buffers hold.
REQ-022 An accepted word with in_sel=3 shall be dropped, with no change to any channel.
REQ-023 On that drop, err shall be 1 on the next cycle, and err_count shall increment by 1, saturating at 255 with no wrap.
REQ-024 err shall be 0 in every cycle that does not follow an illegal accept.
REQ-025 Back-to-back accepts to the same channel at full throughput shall be sustained while its outN_ready=1 every cycle.

Reset
REQ-026 While rst_n=0 at a clock edge: all outN_valid=0, all outN_data=0, err=0, err_count=0.
REQ-027 Reset mid-operation shall discard buffered words without delivering them.
REQ-028 While rst_n=0, in_ready shall be 0, and no input transfer shall be recorded.
REQ-029 The first accept shall be possible in the cycle after rst_n returns to 1.

Verification
REQ-030 Reset, then in_sel=1, in_data=0xDEADBEEF, in_valid=1 for 1 cycle, out1_ready=0 -> next cycle out1_valid=1, out1_data=0xDEADBEEF; out0_valid=0 and out2_valid=0; the word holds for 5 cycles.
REQ-031 ch2 FULL with 0x11, out2_ready=0, then in_sel=2, in_data=0x22 -> in_ready=0 and out2_data stays 0x11; raise out2_ready -> same cycle in_ready=1, next cycle out2_data=0x22.
REQ-032 Stream 0x1,0x2,0x3,0x4 to ch0 on consecutive cycles with out0_ready=1 -> out0_data shows 0x1..0x4 on consecutive cycles, no gaps and no duplicates.
REQ-033 Accept in_sel=3 three times -> err pulses 3 times, err_count=3, no outN_valid asserted; after 300 illegal accepts err_count=255.
REQ-034 ch0 and ch2 FULL, then rst_n=0 for 1 cycle -> all outN_valid=0, all outN_data=0, err_count=0, in_ready=0 during reset.
REQ-035 ch1 FULL and stalled, then in_sel=0 accepted -> in_ready=1, ch0 loads, and ch1 data and valid are unchanged.
